seq011_tx: RTL and testbench
============================

SEQ011_TX -- requirements
Module: seq011_tx

Interface
REQ-001 SHALL have parameter PATTERN, default 3'b011, the 3-bit serial pattern, transmitted MSB first.
REQ-002 SHALL have parameter CNT_W, default 8, the width of the repetition count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin a transmission burst.
REQ-006 SHALL have port rep_count, input, CNT_W bits: number of pattern repetitions, sampled with start.
REQ-007 SHALL have port x, output, 1 bit: serial data bit.
REQ-008 SHALL have port valid, output, 1 bit: x carries a pattern bit this cycle.
REQ-009 SHALL have port busy, output, 1 bit: a burst is in progress (state != IDLE).
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse at burst completion.
REQ-011 SHALL have port sent_cnt, output, 3 bits: completed patterns since reset, modulo 8.

Function
REQ-012 SHALL implement FSM states IDLE, BIT2, BIT1, BIT0, GAP (macro only) and DONE.
REQ-013 SHALL derive x, valid, busy and done from the registered state only (Moore outputs).
REQ-014 SHALL drive x=PATTERN[2]/[1]/[0] with valid=1 in BIT2/BIT1/BIT0, and x=0 with valid=0 in all other states.
REQ-015 SHALL, in IDLE with start=1 and rep_count!=0, latch rep_count into a remaining counter and enter BIT2 on the next edge; the first valid bit appears one cycle after start.
REQ-016 SHALL ignore start in IDLE when rep_count=0: no state change and no done pulse.
REQ-017 SHALL ignore start and rep_count whenever busy=1; a burst is never restarted or extended.
REQ-018 SHALL transition BIT2->BIT1->BIT0 unconditionally, one cycle each.
REQ-019 SHALL, from BIT0, decrement remaining and go to DONE if remaining was 1, else go to BIT2 (or GAP, see REQ-026).
REQ-020 SHALL hold done=1 for exactly the one DONE cycle, then return to IDLE; start is accepted again from the IDLE cycle onward.
REQ-021 SHALL increment sent_cnt by 1 at each BIT0 exit, wrapping 7->0; sent_cnt is cleared only by rst.
REQ-022 SHALL give a burst length of 3*N valid cycles plus 1 DONE cycle for rep_count=N (no macro); the maximum N is 2^CNT_W-1.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, force state=IDLE, remaining=0 and sent_cnt=0, giving x=0, valid=0, busy=0 and done=0 from the next cycle.
REQ-024 SHALL give rst priority over start, including mid-burst; an aborted burst produces no done pulse.

Configuration
REQ-025 SHALL use macro SEQ011_TX_GAP_EN.
REQ-026 SHALL, with SEQ011_TX_GAP_EN defined, insert one GAP cycle (x=0, valid=0, busy=1) between consecutive repetitions, never after the last, so a burst is 4*N-1 valid/gap cycles plus DONE; without the macro, the GAP state and logic are absent and repetitions are back-to-back.

Structure
REQ-027 SHALL place the state encoding type and the default PATTERN constant in shared package seq011_pkg.
REQ-028 SHALL implement remaining as sub-module seq011_rep_cnt (CNT_W-bit load/decrement down-counter with last flag).

Verification
REQ-029 SHALL cover: rst, start=1 with rep_count=1 -> x=0,1,1 with valid=1 on cycles 1-3 after start, done=1 on cycle 4, sent_cnt=1.
REQ-030 SHALL cover: rep_count=3, no macro -> valid high for 9 consecutive cycles with x=011011011, done on cycle 10, sent_cnt=3.
REQ-031 SHALL cover: rep_count=0 with start=1 -> busy, valid and done stay 0 for 10 cycles.
REQ-032 SHALL cover: start pulsed again mid-burst with rep_count=5 (original 2) -> exactly 6 valid bits, and one done pulse.
REQ-033 SHALL cover: rst asserted in BIT1 of the second repetition -> next cycle IDLE with sent_cnt=0 and no done.
REQ-034 SHALL cover: macro defined, rep_count=9 -> x/valid sequence 011,gap repeated, 27 valid bits, sent_cnt wraps to 1.

Source files
------------

// File: rtl/seq011_pkg.sv
// Shared types and helpers for the seq011 serial pattern transmitter.
// Optional build macro SEQ011_TX_GAP_EN adds the GAP state between repetitions.
package seq011_pkg;

    localparam logic [2:0] DEFAULT_PATTERN = 3'b011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIT2 = 3'd1,
        BIT1 = 3'd2,
        BIT0 = 3'd3,
`ifdef SEQ011_TX_GAP_EN
        GAP  = 3'd5,
`endif
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic x;
        logic valid;
        logic busy;
        logic done;
    } tx_out_t;

    // Moore output decode: everything visible on the pins is a function of state alone.
    function automatic tx_out_t decode_state(input state_t s, input logic [2:0] pattern);
        tx_out_t o;
        o = '0;
        case (s)
            BIT2: begin o.x = pattern[2]; o.valid = 1'b1; o.busy = 1'b1; end
            BIT1: begin o.x = pattern[1]; o.valid = 1'b1; o.busy = 1'b1; end
            BIT0: begin o.x = pattern[0]; o.valid = 1'b1; o.busy = 1'b1; end
`ifdef SEQ011_TX_GAP_EN
            GAP:  o.busy = 1'b1;
`endif
            DONE: begin o.busy = 1'b1; o.done = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/seq011_rep_cnt.sv
// Repetition down-counter: loads the burst length, decrements once per pattern,
// and flags the final repetition.
module seq011_rep_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] remaining_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_reg <= '0;
        end else if (load) begin
            remaining_reg <= load_val;
        end else if (dec && remaining_reg != '0) begin
            remaining_reg <= remaining_reg - CNT_W'(1);
        end
    end

    assign last = (remaining_reg == CNT_W'(1));

endmodule

// File: rtl/seq011_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first rep_count times per start.
// Build macro SEQ011_TX_GAP_EN inserts one idle GAP cycle between repetitions.
module seq011_tx
    import seq011_pkg::*;
#(
    parameter logic [2:0] PATTERN = DEFAULT_PATTERN,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_count,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       sent_cnt
);

    state_t     state_reg;
    state_t     state_next;
    tx_out_t    out_reg;
    logic [2:0] sent_cnt_reg;
    logic       load;
    logic       dec;
    logic       last;

    seq011_rep_cnt #(
        .CNT_W(CNT_W)
    ) u_rep_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (rep_count),
        .dec      (dec),
        .last     (last)
    );

    // start/rep_count are only looked at in IDLE, so a running burst can't be disturbed.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        dec        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && rep_count != '0) begin
                    state_next = BIT2;
                    load       = 1'b1;
                end
            end
            BIT2: state_next = BIT1;
            BIT1: state_next = BIT0;
            BIT0: begin
                dec = 1'b1;
                if (last) begin
                    state_next = DONE;
                end else begin
`ifdef SEQ011_TX_GAP_EN
                    state_next = GAP;
`else
                    state_next = BIT2;
`endif
                end
            end
`ifdef SEQ011_TX_GAP_EN
            GAP:  state_next = BIT2;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            out_reg      <= '0;
            sent_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= decode_state(state_next, PATTERN);
            if (dec) begin
                sent_cnt_reg <= sent_cnt_reg + 3'd1;
            end
        end
    end

    assign x        = out_reg.x;
    assign valid    = out_reg.valid;
    assign busy     = out_reg.busy;
    assign done     = out_reg.done;
    assign sent_cnt = sent_cnt_reg;

endmodule

// File: tb/tb_seq011_tx.sv
// Self-checking bench for seq011_tx: directed scenarios followed by random traffic,
// all checked cycle-by-cycle against a queue-based model of the expected waveform.
module tb_seq011_tx;

    localparam logic [2:0] PAT = 3'b011;

    typedef struct {
        logic       x;
        logic       valid;
        logic       busy;
        logic       done;
        logic [2:0] sent;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] rep_count;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;
    logic [2:0] sent_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t       q[$];
    logic [2:0] model_sent = 3'd0;

    seq011_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rep_count (rep_count),
        .x         (x),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    // One clock: check the current cycle at the falling edge, then drive the inputs
    // that the next rising edge will sample and extend the expected waveform.
    task automatic tick(input logic r, input logic s, input logic [7:0] n);
        exp_t e;
        logic idle;
        @(negedge clk);
        cyc++;
        if (q.size() > 0) begin
            e    = q.pop_front();
            idle = 1'b0;
        end else begin
            e    = '{x: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, sent: model_sent};
            idle = 1'b1;
        end
        chk("x",        {2'b00, x},     {2'b00, e.x});
        chk("valid",    {2'b00, valid}, {2'b00, e.valid});
        chk("busy",     {2'b00, busy},  {2'b00, e.busy});
        chk("done",     {2'b00, done},  {2'b00, e.done});
        chk("sent_cnt", sent_cnt,       e.sent);

        if (r) begin
            q.delete();
            model_sent = 3'd0;
        end else if (idle && s && n != 8'd0) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int b = 2; b >= 0; b--) begin
                    q.push_back('{x: PAT[b], valid: 1'b1, busy: 1'b1, done: 1'b0,
                                  sent: 3'(int'(model_sent) + i)});
                end
`ifdef SEQ011_TX_GAP_EN
                if (i != int'(n) - 1) begin
                    q.push_back('{x: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0,
                                  sent: 3'(int'(model_sent) + i + 1)});
                end
`endif
            end
            q.push_back('{x: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1,
                          sent: 3'(int'(model_sent) + int'(n))});
            model_sent = 3'(int'(model_sent) + int'(n));
        end
        rst       = r;
        start     = s;
        rep_count = n;
    endtask

    task automatic idle_ticks(input int k);
        for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        int rst_delay;
        logic r, s;
        logic [7:0] n;
`ifdef SEQ011_TX_GAP_EN
        rst_delay = 5;
`else
        rst_delay = 4;
`endif
        rst       = 1'b1;
        start     = 1'b0;
        rep_count = 8'd0;
        @(posedge clk);

        // Reset state, then a single repetition.
        tick(1'b1, 1'b0, 8'd0);
        tick(1'b0, 1'b1, 8'd1);
        idle_ticks(6);

        // Three repetitions.
        tick(1'b0, 1'b1, 8'd3);
        idle_ticks(14);

        // rep_count = 0 is ignored.
        tick(1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 8'd0);
        idle_ticks(2);

        // Start pulsed again mid-burst must not extend it.
        tick(1'b0, 1'b1, 8'd2);
        tick(1'b0, 1'b1, 8'd5);
        tick(1'b0, 1'b1, 8'd5);
        idle_ticks(12);

        // Reset during BIT1 of the second repetition aborts silently.
        tick(1'b0, 1'b1, 8'd3);
        idle_ticks(rst_delay);
        tick(1'b1, 1'b0, 8'd0);
        idle_ticks(6);

        // Nine repetitions from a clean count: sent_cnt wraps to 1.
        tick(1'b1, 1'b0, 8'd0);
        tick(1'b0, 1'b1, 8'd9);
        idle_ticks(40);

        // Random traffic, including occasional resets and zero counts.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 3) == 0);
            n = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            tick(r, s, n);
        end
        idle_ticks(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
